// File: rtl/des_sbox_pipe.sv
// des_sbox_pipe: pipelined DES substitution stage.
//   Applies S-boxes 1..8 to LANES independent 48-bit words per beat. The
//   lookup is combinational on in_data and captured into stage 0. Later
//   stages only move data, and out_* come from the last stage register.
//   Uses a valid/ready handshake with per-stage bubble collapse, a sideband
//   tag, a synchronous flush and registered occupancy.
// Ports:
//   clk, rst_n         rising-edge clock, async active-low reset
//   flush              clears every stage valid (data regs keep value)
//   in_valid/in_ready  input handshake; in_ready is combinational from out_ready
//   in_data [0:48L-1]  lane l at bits [48l : 48l+47], MSB-first
//   in_tag             sideband tag, returned unchanged with the beat
//   out_valid/out_ready output handshake
//   out_data [0:32L-1] lane l at bits [32l : 32l+31]
//   out_tag            tag of the presented beat
//   occupancy          popcount of stage valids (registered)

// Generic S-box ROM. idx is the raw 6-bit slice [0:5]: row = {b0,b5},
// col = b1..b4. T holds the 64 entries row-major, entry 0 in the top nibble.
module des_sbox_rom #(
  parameter logic [0:255] T = '0
) (
  input  logic [0:5] idx,
  output logic [0:3] val
);
  logic [5:0] ent;
  assign ent = {idx[0], idx[5], idx[1:4]};
  assign val = T[{ent, 2'b00} +: 4];
endmodule

module Sbox1 (input logic [0:5] idx, output logic [0:3] val);
  des_sbox_rom #(.T(256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D))
    u_rom (.idx(idx), .val(val));
endmodule

module Sbox2 (input logic [0:5] idx, output logic [0:3] val);
  des_sbox_rom #(.T(256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9))
    u_rom (.idx(idx), .val(val));
endmodule

module Sbox3 (input logic [0:5] idx, output logic [0:3] val);
  des_sbox_rom #(.T(256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C))
    u_rom (.idx(idx), .val(val));
endmodule

module Sbox4 (input logic [0:5] idx, output logic [0:3] val);
  des_sbox_rom #(.T(256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E))
    u_rom (.idx(idx), .val(val));
endmodule

module Sbox5 (input logic [0:5] idx, output logic [0:3] val);
  des_sbox_rom #(.T(256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453))
    u_rom (.idx(idx), .val(val));
endmodule

module Sbox6 (input logic [0:5] idx, output logic [0:3] val);
  des_sbox_rom #(.T(256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D))
    u_rom (.idx(idx), .val(val));
endmodule

module Sbox7 (input logic [0:5] idx, output logic [0:3] val);
  des_sbox_rom #(.T(256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C))
    u_rom (.idx(idx), .val(val));
endmodule

module Sbox8 (input logic [0:5] idx, output logic [0:3] val);
  des_sbox_rom #(.T(256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B))
    u_rom (.idx(idx), .val(val));
endmodule

// One 48-bit lane: slice k-1 feeds S-box k, result nibble k-1.
module des_sbox_lane (
  input  logic [0:47] din,
  output logic [0:31] dout
);
  Sbox1 u_s1 (.idx(din[0:5]),   .val(dout[0:3]));
  Sbox2 u_s2 (.idx(din[6:11]),  .val(dout[4:7]));
  Sbox3 u_s3 (.idx(din[12:17]), .val(dout[8:11]));
  Sbox4 u_s4 (.idx(din[18:23]), .val(dout[12:15]));
  Sbox5 u_s5 (.idx(din[24:29]), .val(dout[16:19]));
  Sbox6 u_s6 (.idx(din[30:35]), .val(dout[20:23]));
  Sbox7 u_s7 (.idx(din[36:41]), .val(dout[24:27]));
  Sbox8 u_s8 (.idx(din[42:47]), .val(dout[28:31]));
endmodule

module des_sbox_pipe #(
  parameter int LANES  = 1,
  parameter int STAGES = 2,
  parameter int TAG_W  = 4,
  localparam int OCC_W = $clog2(STAGES+1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [0:48*LANES-1]    in_data,
  input  logic [TAG_W-1:0]       in_tag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [0:32*LANES-1]    out_data,
  output logic [TAG_W-1:0]       out_tag,
  output logic [OCC_W-1:0]       occupancy
);
  logic [0:32*LANES-1]                 sub;
  logic [STAGES-1:0]                   vld_pipe, vld_nxt, adv;
  logic [STAGES-1:0][0:32*LANES-1]     dat_q;
  logic [STAGES-1:0][TAG_W-1:0]        tag_q;
  logic [OCC_W-1:0]                    occ_nxt;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    des_sbox_lane u_lane (.din(in_data[48*l +: 48]), .dout(sub[32*l +: 32]));
  end

  // Stage s may advance when the output drains or any stage at or above s
  // holds a bubble. Written flat per stage so there is no comb self-loop.
  for (genvar s = 0; s < STAGES; s++) begin : g_adv
    assign adv[s] = out_ready | ~(&vld_pipe[STAGES-1:s]);
  end

  assign in_ready  = adv[0];
  assign out_valid = vld_pipe[STAGES-1];
  assign out_data  = dat_q[STAGES-1];
  assign out_tag   = tag_q[STAGES-1];

  always_comb begin
    vld_nxt = vld_pipe;
    if (flush) begin
      vld_nxt = '0;
    end else begin
      if (adv[0]) vld_nxt[0] = in_valid;
      for (int s = 1; s < STAGES; s++)
        if (adv[s]) vld_nxt[s] = vld_pipe[s-1];
    end
  end

  always_comb begin
    occ_nxt = '0;
    for (int s = 0; s < STAGES; s++)
      occ_nxt = occ_nxt + OCC_W'(vld_nxt[s]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe  <= '0;
      dat_q     <= '0;
      tag_q     <= '0;
      occupancy <= '0;
    end else begin
      vld_pipe  <= vld_nxt;
      occupancy <= occ_nxt;
      // Flush only drops valids; payload registers are left as they were.
      if (!flush) begin
        // Stage 0 only captures real beats so idle don't-care inputs never land.
        if (adv[0] && in_valid) begin
          dat_q[0] <= sub;
          tag_q[0] <= in_tag;
        end
        for (int s = 1; s < STAGES; s++)
          if (adv[s]) begin
            dat_q[s] <= dat_q[s-1];
            tag_q[s] <= tag_q[s-1];
          end
      end
    end
  end
endmodule

// File: tb/tb_des_sbox_pipe.sv
module tb_des_sbox_pipe;
  localparam int LANES = 2, STAGES = 3, TAG_W = 4;

  logic clk = 1'b0;
  logic rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [0:95] in_data;
  logic [3:0]  in_tag, out_tag;
  logic [0:63] out_data;
  logic [1:0]  occupancy;

  always #5 clk = ~clk;

  des_sbox_pipe #(.LANES(LANES), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
    .in_ready(in_ready), .in_data(in_data), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_tag(out_tag), .occupancy(occupancy));

  // Standard DES S-box tables, decimal, row-major (4 rows x 16 columns).
  int SB [8][64] = '{
    '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8, 4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
    '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5, 0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
    '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1, 13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
    '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9, 10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
    '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6, 4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
    '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8, 9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
    '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6, 1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
    '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2, 7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}};

  typedef struct { logic [63:0] d; logic [3:0] t; } beat_t;
  beat_t q[$];

  int checks = 0, errors = 0;
  int emitted, drops, nt;
  logic in_x, out_x, stall_prev, stall_nxt, rdy_s;
  logic [63:0] prev_data, got;
  logic [3:0]  prev_tag;

  // six[5] is the first (MSB) bit of the slice.
  function automatic logic [3:0] sref(int k, logic [5:0] six);
    int row = int'(six[5]) * 2 + int'(six[0]);
    int col = int'(six[4:1]);
    return 4'(SB[k][row*16 + col]);
  endfunction

  function automatic logic [31:0] lane_ref(logic [47:0] w);
    logic [31:0] r;
    for (int k = 0; k < 8; k++) r[31-4*k -: 4] = sref(k, w[47-6*k -: 6]);
    return r;
  endfunction

  function automatic logic [63:0] beat_ref(logic [95:0] w);
    return {lane_ref(w[95:48]), lane_ref(w[47:0])};
  endfunction

  task automatic chk(input string nm, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", nm, obs, exp);
    end
  endtask

  // Sample at the falling edge and score against the model.
  task automatic samp();
    logic exp_rdy;
    @(negedge clk);
    exp_rdy = (q.size() < STAGES) || out_ready;
    rdy_s = in_ready;
    chk("occupancy", 64'(occupancy), 64'(q.size()));
    chk("in_ready", 64'(in_ready), 64'(exp_rdy));
    if (stall_prev) begin
      chk("hold_valid", 64'(out_valid), 64'd1);
      chk("hold_data", out_data, prev_data);
      chk("hold_tag", 64'(out_tag), 64'(prev_tag));
    end
    if (out_valid === 1'b1) begin
      if (q.size() == 0) chk("spurious_out", 64'(out_valid), 64'd0);
      else begin
        chk("out_data", out_data, q[0].d);
        chk("out_tag", 64'(out_tag), 64'(q[0].t));
      end
    end
    in_x      = in_valid & exp_rdy & ~flush;
    out_x     = (out_valid === 1'b1) & out_ready;
    stall_nxt = (out_valid === 1'b1) & ~out_ready & ~flush;
    prev_data = out_data;
    prev_tag  = out_tag;
  endtask

  task automatic adv_clk();
    @(posedge clk); #1;
    if (out_x) emitted++;
    if (flush) q.delete();
    else begin
      if (out_x && q.size() > 0) void'(q.pop_front());
      if (in_x) q.push_back('{d: beat_ref(in_data), t: in_tag});
    end
    stall_prev = stall_nxt;
  endtask

  task automatic step();
    samp();
    adv_clk();
  endtask

  function automatic logic [95:0] rnd96();
    return {$urandom(), $urandom(), $urandom()};
  endfunction

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_data = '0; in_tag = '0; stall_prev = 1'b0; emitted = 0;
    #12;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_out_tag", 64'(out_tag), 64'd0);
    chk("rst_occupancy", 64'(occupancy), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Directed: lane 0 all-zero, lane 1 all-one; latency STAGES-1 edges.
    out_ready = 1'b1; in_valid = 1'b1; in_tag = 4'h3;
    in_data = {48'h0, 48'hFFFFFFFFFFFF};
    step();
    in_valid = 1'b0;
    samp(); chk("lat_edge_n", 64'(out_valid), 64'd0); adv_clk();
    samp(); chk("lat_edge_n1", 64'(out_valid), 64'd0); adv_clk();
    samp();
    chk("lat_valid", 64'(out_valid), 64'd1);
    chk("zero_ones_data", out_data, 64'hEFA72C4D_D9CE3DCB);
    chk("zero_ones_tag", 64'(out_tag), 64'h3);
    chk("lat_occ", 64'(occupancy), 64'd1);
    adv_clk();

    // S-box 3 slice = 000001, everything else zero.
    in_valid = 1'b1; in_tag = 4'h5;
    in_data = {48'h0000_4000_0000, 48'h0};
    step();
    in_valid = 1'b0; got = '0;
    for (int c = 0; c < 6; c++) begin
      samp();
      if (out_valid === 1'b1) got = out_data;
      adv_clk();
    end
    chk("sbox3_slice", got, 64'hEFD72C4D_EFA72C4D);

    // Backpressure: 5 tagged beats, out_ready low from cycle 2.
    emitted = 0; nt = 0; out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (c == 2) out_ready = 1'b0;
      in_valid = (nt < 5); in_tag = 4'(nt); in_data = rnd96();
      samp();
      if (in_x) nt++;
      adv_clk();
    end
    samp();
    chk("bp_accepted", 64'(nt), 64'd3);
    chk("bp_in_ready", 64'(in_ready), 64'd0);
    chk("bp_occ", 64'(occupancy), 64'd3);
    adv_clk();
    out_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      in_valid = (nt < 5); in_tag = 4'(nt); in_data = rnd96();
      samp();
      if (in_x) nt++;
      adv_clk();
    end
    chk("bp_emitted", 64'(emitted), 64'd5);

    // Full throughput: 20 back-to-back beats, in_ready must never drop.
    emitted = 0; drops = 0; out_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      in_valid = 1'b1; in_tag = 4'(c); in_data = rnd96();
      samp();
      if (rdy_s !== 1'b1) drops++;
      adv_clk();
    end
    in_valid = 1'b0;
    for (int c = 0; c < 5; c++) step();
    chk("tp_in_ready_drops", 64'(drops), 64'd0);
    chk("tp_emitted", 64'(emitted), 64'd20);

    // Flush with two beats resident and a concurrent input.
    out_ready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      in_valid = 1'b1; in_tag = 4'(9 + c); in_data = rnd96();
      step();
    end
    flush = 1'b1; in_valid = 1'b1; in_tag = 4'hC; in_data = rnd96();
    samp();
    chk("flush_pre_occ", 64'(occupancy), 64'd2);
    chk("flush_in_ready", 64'(in_ready), 64'd1);
    adv_clk();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; emitted = 0;
    samp();
    chk("flush_occ", 64'(occupancy), 64'd0);
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    adv_clk();
    for (int c = 0; c < 5; c++) step();
    chk("flush_no_out", 64'(emitted), 64'd0);

    // Mid-cycle asynchronous reset with a full, stalled pipeline.
    out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      in_valid = 1'b1; in_tag = 4'(c + 1); in_data = rnd96();
      step();
    end
    in_valid = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_out_data", out_data, 64'd0);
    chk("arst_out_tag", 64'(out_tag), 64'd0);
    chk("arst_occ", 64'(occupancy), 64'd0);
    q.delete(); stall_prev = 1'b0;
    @(negedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b1;
    step();

    // Random traffic with occasional flush.
    for (int c = 0; c < 300; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      in_tag    = 4'($urandom());
      in_data   = rnd96();
      step();
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 6; c++) step();
    chk("drain_empty", 64'(occupancy), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
